// File: rtl/jtframe_linesched.sv
// Line-render scheduler: sequences the enabled tile layers of each scan line through
// one shared scan/write port, addressing a double-buffered line RAM as {line, layer, hscan}.
module jtframe_linesched #(
    parameter int unsigned     HW     = 8,
    parameter int unsigned     VW     = 8,
    parameter int unsigned     LAYERS = 2,
    parameter int unsigned     LW     = 2,
    parameter logic [HW-1:0]   HOVER  = '1,
    parameter logic [HW-1:0]   HSTART = '0,
    parameter logic [HW-1:0]   HEND   = '1
) (
    input  logic               rst,
    input  logic               clk,
    input  logic               pxl2_cen,
    input  logic [HW-1:0]      hdump,
    input  logic [VW-1:0]      vdump,
    input  logic [LAYERS-1:0]  layer_en,
    input  logic               rom_ok,
    output logic               scan_cen,
    output logic [HW-1:0]      hscan,
    output logic [VW-1:0]      vscan,
    output logic [LW-1:0]      layer,
    output logic               we,
    output logic [LW+HW:0]     buf_addr,
    output logic               line,
    output logic               busy,
    output logic               line_done,
    output logic               overrun
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SCAN  = 2'd2;
    localparam logic [1:0] NEXT  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [HW-1:0]     hscan_q, hscan_d;
    logic [VW-1:0]     vscan_q, vscan_d;
    logic [LW-1:0]     layer_q, layer_d;
    logic              line_q, line_d;
    logic [LAYERS-1:0] en_l_q, en_l_d;
    logic [HW-1:0]     hdump_l_q;
    logic              line_done_q, line_done_d;
    logic              overrun_q, overrun_d;

    logic              ls;
    logic [LW-1:0]     first_idx;
    logic [LW-1:0]     nxt_idx;
    logic              nxt_vld;

    assign ls = (hdump == HOVER) && (hdump_l_q != HOVER);

    // Lowest layer requested at line start, and next enabled layer above the current one
    always_comb begin
        first_idx = '0;
        nxt_idx   = '0;
        nxt_vld   = 1'b0;
        for (int i = int'(LAYERS) - 1; i >= 0; i--) begin
            if (layer_en[i]) first_idx = LW'(i);
            if (en_l_q[i] && (i > int'(layer_q))) begin
                nxt_idx = LW'(i);
                nxt_vld = 1'b1;
            end
        end
    end

    assign scan_cen = pxl2_cen & rom_ok & (state_q == SCAN);

    always_comb begin
        state_d     = state_q;
        hscan_d     = hscan_q;
        vscan_d     = vscan_q;
        layer_d     = layer_q;
        line_d      = line_q;
        en_l_d      = en_l_q;
        line_done_d = 1'b0;
        overrun_d   = 1'b0;
        if (ls) begin
            // A new line always wins; any unfinished render is dropped
            line_d    = ~line_q;
            vscan_d   = vdump + VW'(1);
            en_l_d    = layer_en;
            overrun_d = (state_q != IDLE);
            layer_d   = first_idx;
            if (layer_en == '0) begin
                state_d     = IDLE;
                line_done_d = (state_q == IDLE);
            end else begin
                state_d = SETUP;
            end
        end else begin
            case (state_q)
                SETUP: begin
                    hscan_d = HSTART;
                    state_d = SCAN;
                end
                SCAN: begin
                    if (scan_cen) begin
                        if (hscan_q == HEND) state_d = NEXT;
                        else                 hscan_d = hscan_q + HW'(1);
                    end
                end
                NEXT: begin
                    if (nxt_vld) begin
                        layer_d = nxt_idx;
                        state_d = SETUP;
                    end else begin
                        state_d     = IDLE;
                        line_done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hscan_q     <= '0;
            vscan_q     <= '0;
            layer_q     <= '0;
            line_q      <= 1'b0;
            en_l_q      <= '0;
            hdump_l_q   <= '0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hscan_q     <= hscan_d;
            vscan_q     <= vscan_d;
            layer_q     <= layer_d;
            line_q      <= line_d;
            en_l_q      <= en_l_d;
            hdump_l_q   <= hdump;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign hscan     = hscan_q;
    assign vscan     = vscan_q;
    assign layer     = layer_q;
    assign line      = line_q;
    assign we        = scan_cen;
    assign buf_addr  = {line_q, layer_q, hscan_q};
    assign busy      = (state_q != IDLE);
    assign line_done = line_done_q;
    assign overrun   = overrun_q;

endmodule
